key_load_controller: RTL and testbench
======================================

Name: key_load_controller

Overview:
- Upstream stage of the hardware-locked RV32I core.
- Receives the 64-bit unlock key over a 1-bit serial valid/ready link, followed by an 8-bit checksum, and verifies the checksum.
- Drives the core's 64-bit key bus and holds the core in reset until a verified key is present.
- Counts failed load attempts and enters a sticky lockout after MAX_FAILS failures.

Parameters:
- KEY_WIDTH, 64, key length in bits; must be a multiple of 8.
- MAX_FAILS, 3, consecutive checksum failures before lockout; range 1..3.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle request to begin or restart a key load.
- ser_valid  input  1  serial bit present on ser_data.
- ser_data  input  1  serial key/checksum bit, MSB first.
- ser_ready  output  1  block accepts a serial bit this cycle.
- key  output  KEY_WIDTH  verified key to the core; all zeros unless key_valid.
- key_valid  output  1  key holds a verified value.
- core_rst  output  1  reset to the core; high unless key_valid.
- load_error  output  1  one-cycle pulse on checksum mismatch.
- lockout  output  1  sticky lockout indicator.
- fail_count  output  2  consecutive failed attempts.

Behaviour:
- Clocking and reset:
  - One clock domain; clk and rst are fixed as above.
  - All outputs are registered.
  - On rst: state = IDLE; key = 0; key_valid = 0; core_rst = 1; ser_ready = 0; load_error = 0; lockout = 0; fail_count = 0; shift register and bit counter cleared.
  - rst asserted mid-load or in ACTIVE aborts immediately. The key is lost and must be reloaded.
- Transfer rule: a bit transfers when ser_valid && ser_ready on a rising edge. The shift register shifts left and ser_data enters the LSB.
- IDLE:
  - ser_ready = 0.
  - load_start moves to SHIFT_KEY and clears the bit counter.
- SHIFT_KEY:
  - ser_ready = 1.
  - Accepts KEY_WIDTH bits, first bit = key MSB.
  - After the KEY_WIDTH-th transfer: move to SHIFT_CHK with the counter cleared.
- SHIFT_CHK:
  - ser_ready = 1.
  - Accepts 8 checksum bits, MSB first.
  - After the 8th transfer: move to CHECK.
- Stalls: ser_valid low in either shift state holds state and counter indefinitely. There is no timeout.
- Restart: load_start in SHIFT_KEY or SHIFT_CHK restarts at SHIFT_KEY with the counter cleared. A simultaneous serial bit is discarded.
- CHECK (one cycle, ser_ready = 0):
  - Expected checksum = XOR of all KEY_WIDTH/8 bytes of the received key.
  - Match: next state ACTIVE; the key register loads the received key; fail_count = 0.
  - Mismatch: load_error pulses for exactly one cycle; fail_count increments (saturates at 3).
  - Mismatch with the new fail_count == MAX_FAILS: next state LOCKOUT.
  - Otherwise on mismatch: next state IDLE.
- ACTIVE:
  - key_valid = 1; core_rst = 0; ser_ready = 0.
  - load_start (rekey): next state SHIFT_KEY; key, key_valid and core_rst return to their reset values on that same edge.
- LOCKOUT:
  - lockout = 1; core_rst = 1; key = 0; ser_ready = 0.
  - All inputs are ignored. Exit only via rst.
- Latency: last checksum bit accepted at edge N → CHECK during cycle N+1 → key_valid / core_rst change visible after edge N+2. load_error is visible after edge N+2 for one cycle.
- fail_count clears only on a successful check or on rst; it is not cleared by a rekey.
- The key output is never partially updated. It changes only on the CHECK→ACTIVE transition or when clearing.

Test Plan:
- Reset, then load key 64'hDEAD_BEEF_0000_0001 with checksum 8'h23, no stalls → key = 64'hDEAD_BEEF_0000_0001, key_valid = 1 and core_rst = 0 exactly 2 edges after the last bit; fail_count = 0.
- Same key with checksum 8'h22 → load_error one-cycle pulse, fail_count = 1, state IDLE, key = 0, core_rst = 1.
- Three consecutive bad loads (MAX_FAILS = 3) → lockout = 1 after the third. A subsequent correct load_start plus bits leaves ser_ready = 0 and key = 0. rst clears lockout and fail_count.
- Correct load with ser_valid deasserted for 10 random cycles mid-key, plus load_start asserted after 20 key bits followed by a full correct load → only the post-restart bits are used; key correct.
- While ACTIVE, pulse load_start → key = 0 and core_rst = 1 on the next edge. Reload 64'h0123_4567_89AB_CDEF with checksum 8'h00 → key_valid = 1.
- Assert rst asynchronously, between clock edges, 40 bits into a load → all outputs reach reset values before the next edge; a following full correct load succeeds.

Source files
------------

// File: rtl/key_load_controller.sv
// Serial unlock-key loader for the locked RV32I core: shifts in key + checksum,
// verifies the byte-XOR checksum and holds the core in reset until a key is good.
module key_load_controller #(
   parameter int KEY_WIDTH = 64,
   parameter int MAX_FAILS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic                 ser_valid,
   input  logic                 ser_data,
   output logic                 ser_ready,
   output logic [KEY_WIDTH-1:0] key,
   output logic                 key_valid,
   output logic                 core_rst,
   output logic                 load_error,
   output logic                 lockout,
   output logic [1:0]           fail_count
);

   localparam int SW = KEY_WIDTH + 8;
   localparam int CW = $clog2(KEY_WIDTH);
   localparam int NB = KEY_WIDTH / 8;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_KEY,
      SHIFT_CHK,
      CHECK,
      ACTIVE,
      LOCKOUT
   } state_t;

   state_t               state_q, state_d;
   logic [SW-1:0]        sh_q, sh_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           fail_q, fail_d;
   logic                 err_q, err_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 key_valid_q, key_valid_d;
   logic                 core_rst_q, core_rst_d;
   logic                 ser_ready_q, ser_ready_d;
   logic                 load_error_q, load_error_d;
   logic                 lockout_q, lockout_d;

   logic       xfer;
   logic       last_key;
   logic       last_chk;
   logic [7:0] sum;
   logic       match;
   logic [1:0] fail_inc;

   assign xfer     = ser_valid && ser_ready_q;
   assign last_key = (cnt_q == CW'(KEY_WIDTH - 1));
   assign last_chk = (cnt_q == CW'(7));
   assign fail_inc = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

   // Key occupies sh_q[SW-1:8], received checksum sits in the low byte.
   always_comb begin
      sum = 8'h00;
      for (int i = 0; i < NB; i++) begin
         sum = sum ^ sh_q[8 + 8*i +: 8];
      end
   end

   assign match = (sum == sh_q[7:0]);

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = SHIFT_KEY;
               cnt_d   = '0;
            end
         end
         SHIFT_KEY: begin
            if (load_start) begin
               cnt_d = '0;
            end else if (xfer) begin
               sh_d  = {sh_q[SW-2:0], ser_data};
               cnt_d = cnt_q + 1'b1;
               if (last_key) begin
                  state_d = SHIFT_CHK;
                  cnt_d   = '0;
               end
            end
         end
         SHIFT_CHK: begin
            if (load_start) begin
               state_d = SHIFT_KEY;
               cnt_d   = '0;
            end else if (xfer) begin
               sh_d  = {sh_q[SW-2:0], ser_data};
               cnt_d = cnt_q + 1'b1;
               if (last_chk) begin
                  state_d = CHECK;
                  cnt_d   = '0;
               end
            end
         end
         CHECK: begin
            if (match) begin
               state_d = ACTIVE;
               fail_d  = 2'd0;
            end else begin
               err_d   = 1'b1;
               fail_d  = fail_inc;
               state_d = (fail_inc == 2'(MAX_FAILS)) ? LOCKOUT : IDLE;
            end
         end
         ACTIVE: begin
            if (load_start) begin
               state_d = SHIFT_KEY;
               cnt_d   = '0;
            end
         end
         LOCKOUT: begin
            state_d = LOCKOUT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Key outputs trail the CHECK verdict by one edge but drop on the rekey edge.
   always_comb begin
      key_valid_d  = (state_q == ACTIVE) && (state_d == ACTIVE);
      key_d        = key_valid_d ? sh_q[SW-1:8] : '0;
      core_rst_d   = !key_valid_d;
      ser_ready_d  = (state_d == SHIFT_KEY) || (state_d == SHIFT_CHK);
      load_error_d = err_q;
      lockout_d    = (state_q == LOCKOUT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sh_q         <= '0;
         cnt_q        <= '0;
         fail_q       <= 2'd0;
         err_q        <= 1'b0;
         key_q        <= '0;
         key_valid_q  <= 1'b0;
         core_rst_q   <= 1'b1;
         ser_ready_q  <= 1'b0;
         load_error_q <= 1'b0;
         lockout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         fail_q       <= fail_d;
         err_q        <= err_d;
         key_q        <= key_d;
         key_valid_q  <= key_valid_d;
         core_rst_q   <= core_rst_d;
         ser_ready_q  <= ser_ready_d;
         load_error_q <= load_error_d;
         lockout_q    <= lockout_d;
      end
   end

   assign ser_ready  = ser_ready_q;
   assign key        = key_q;
   assign key_valid  = key_valid_q;
   assign core_rst   = core_rst_q;
   assign load_error = load_error_q;
   assign lockout    = lockout_q;
   assign fail_count = fail_q;

endmodule

// File: tb/tb_key_load_controller.sv
// Directed bench for key_load_controller: good/bad loads, lockout,
// stalls, restart, rekey and asynchronous reset.
module tb_key_load_controller;

   logic        clk;
   logic        rst;
   logic        load_start;
   logic        ser_valid;
   logic        ser_data;
   logic        ser_ready;
   logic [63:0] key;
   logic        key_valid;
   logic        core_rst;
   logic        load_error;
   logic        lockout;
   logic [1:0]  fail_count;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] K1 = 64'hDEAD_BEEF_0000_0001;
   localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;

   key_load_controller #(
      .KEY_WIDTH(64),
      .MAX_FAILS(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_start(load_start),
      .ser_valid (ser_valid),
      .ser_data  (ser_data),
      .ser_ready (ser_ready),
      .key       (key),
      .key_valid (key_valid),
      .core_rst  (core_rst),
      .load_error(load_error),
      .lockout   (lockout),
      .fail_count(fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   // Sends the top n bits of v MSB first; stalls 10 cycles before bit stall_at.
   task automatic send_bits(input logic [71:0] v, input int n,
                            input int stall_at);
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) begin
            ser_valid = 1'b0;
            repeat (10) step();
            chk("stall_ready", ser_ready, 1'b1);
         end
         ser_valid = 1'b1;
         ser_data  = v[71-i];
         step();
      end
      ser_valid = 1'b0;
      ser_data  = 1'b0;
   endtask

   task automatic load_frame(input logic [63:0] k, input logic [7:0] c,
                             input int stall_at);
      send_bits({k, c}, 72, stall_at);
   endtask

   task automatic expect_ok(input logic [63:0] k);
      step();
      chk("ok_valid_early", key_valid, 1'b0);
      chk("ok_ready_check", ser_ready, 1'b0);
      step();
      chk("ok_valid", key_valid, 1'b1);
      chk("ok_core_rst", core_rst, 1'b0);
      chk("ok_key", key, k);
      chk("ok_fail", fail_count, 2'd0);
      chk("ok_err", load_error, 1'b0);
   endtask

   task automatic expect_bad(input logic [1:0] f, input logic lk);
      step();
      chk("bad_err_early", load_error, 1'b0);
      step();
      chk("bad_err", load_error, 1'b1);
      chk("bad_fail", fail_count, f);
      chk("bad_key", key, 64'h0);
      chk("bad_core_rst", core_rst, 1'b1);
      chk("bad_lockout", lockout, lk);
      step();
      chk("bad_err_end", load_error, 1'b0);
      chk("bad_ready", ser_ready, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      ser_valid  = 1'b0;
      ser_data   = 1'b0;
      repeat (3) step();
      chk("rst_key", key, 64'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_core_rst", core_rst, 1'b1);
      chk("rst_ready", ser_ready, 1'b0);
      chk("rst_err", load_error, 1'b0);
      chk("rst_lockout", lockout, 1'b0);
      chk("rst_fail", fail_count, 2'd0);
      rst = 1'b0;
      step();
      chk("idle_ready", ser_ready, 1'b0);

      pulse_start();
      chk("shift_ready", ser_ready, 1'b1);
      load_frame(K1, 8'h23, -1);
      expect_ok(K1);

      pulse_start();
      chk("rekey_key", key, 64'h0);
      chk("rekey_valid", key_valid, 1'b0);
      chk("rekey_core_rst", core_rst, 1'b1);
      chk("rekey_ready", ser_ready, 1'b1);
      load_frame(K2, 8'h00, -1);
      expect_ok(K2);

      pulse_start();
      load_frame(K1, 8'h22, -1);
      expect_bad(2'd1, 1'b0);
      pulse_start();
      load_frame(K1, 8'h22, -1);
      expect_bad(2'd2, 1'b0);
      pulse_start();
      load_frame(K1, 8'h22, -1);
      expect_bad(2'd3, 1'b1);

      pulse_start();
      chk("lock_ready", ser_ready, 1'b0);
      load_frame(K1, 8'h23, -1);
      repeat (3) step();
      chk("lock_key", key, 64'h0);
      chk("lock_valid", key_valid, 1'b0);
      chk("lock_core_rst", core_rst, 1'b1);
      chk("lock_sticky", lockout, 1'b1);
      chk("lock_fail", fail_count, 2'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("unlock_lockout", lockout, 1'b0);
      chk("unlock_fail", fail_count, 2'd0);

      pulse_start();
      send_bits({K1, 8'h23}, 20, -1);
      load_start = 1'b1;
      ser_valid  = 1'b1;
      ser_data   = 1'b1;
      step();
      load_start = 1'b0;
      ser_valid  = 1'b0;
      ser_data   = 1'b0;
      chk("restart_ready", ser_ready, 1'b1);
      load_frame(K2, 8'h00, int'($urandom_range(1, 63)));
      expect_ok(K2);

      pulse_start();
      send_bits({K1, 8'h23}, 40, -1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_ready", ser_ready, 1'b0);
      chk("arst_valid", key_valid, 1'b0);
      chk("arst_core_rst", core_rst, 1'b1);
      chk("arst_key", key, 64'h0);
      chk("arst_fail", fail_count, 2'd0);
      step();
      rst = 1'b0;
      step();
      pulse_start();
      load_frame(K1, 8'h23, -1);
      expect_ok(K1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
